// File: rtl/sid_audio_out_if.sv
// Sample handshake between the SID filter/mixer and the audio output stage.
interface sid_audio_out_if #(
  parameter int unsigned SAMPLE_W = 15
);
  logic [SAMPLE_W-1:0] sample_in;
  logic                sample_ready;
  logic [3:0]          vol;
  logic                busy;
  logic                overrun;

  modport master (output sample_in, sample_ready, vol, input busy, overrun);
  modport slave  (input sample_in, sample_ready, vol, output busy, overrun);
endinterface

// File: rtl/sid_audio_out.sv
// SID audio output: serial volume scaling followed by a first-order sigma-delta DAC.
// Optional build macro SID_OUT_DITHER_EN adds LFSR dither to the modulator input.
module sid_audio_out #(
  parameter int unsigned SAMPLE_W = 15,
  parameter int unsigned MIDPOINT = 16384
) (
  input  logic                clk,
  input  logic                rst_n,
  sid_audio_out_if.slave      bus,
  output logic                dac_out,
  output logic [SAMPLE_W-1:0] level
);

  localparam int unsigned S_W = SAMPLE_W + 1;
  localparam int unsigned P_W = SAMPLE_W + 5;

  typedef enum logic [2:0] {IDLE, MUL0, MUL1, MUL2, MUL3, LOAD} state_t;

  state_t                state;
  logic signed [S_W-1:0] s;
  logic [3:0]            v;
  logic signed [P_W-1:0] p;
  logic signed [P_W-1:0] s_ext;
  logic signed [P_W-1:0] addend;
  logic signed [P_W-1:0] p_shr;
  logic [SAMPLE_W-1:0]   acc;
  logic [SAMPLE_W:0]     sum;

  assign s_ext = P_W'(s);
  assign p_shr = p >>> 4;

  // Partial product contributed by the current multiplier bit
  always_comb begin
    addend = '0;
    case (state)
      MUL0: if (v[0]) addend = s_ext;
      MUL1: if (v[1]) addend = s_ext <<< 1;
      MUL2: if (v[2]) addend = s_ext <<< 2;
      MUL3: if (v[3]) addend = s_ext <<< 3;
      default: addend = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      s           <= '0;
      v           <= '0;
      p           <= '0;
      level       <= SAMPLE_W'(MIDPOINT);
      bus.busy    <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      bus.overrun <= bus.sample_ready && (state != IDLE);
      case (state)
        IDLE: begin
          if (bus.sample_ready) begin
            s        <= S_W'({1'b0, bus.sample_in}) - S_W'(MIDPOINT);
            v        <= bus.vol;
            p        <= '0;
            state    <= MUL0;
            bus.busy <= 1'b1;
          end
        end
        MUL0: begin p <= p + addend; state <= MUL1; end
        MUL1: begin p <= p + addend; state <= MUL2; end
        MUL2: begin p <= p + addend; state <= MUL3; end
        MUL3: begin p <= p + addend; state <= LOAD; end
        LOAD: begin
          level    <= SAMPLE_W'(p_shr + P_W'(MIDPOINT));
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef SID_OUT_DITHER_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= 16'hACE1;
    else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign sum = {1'b0, acc} + {1'b0, level} + (SAMPLE_W+1)'(lfsr[1:0]);
`else
  assign sum = {1'b0, acc} + {1'b0, level};
`endif

  // Sigma-delta modulator: carry out of the level accumulator is the bitstream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      dac_out <= 1'b0;
    end else begin
      acc     <= sum[SAMPLE_W-1:0];
      dac_out <= sum[SAMPLE_W];
    end
  end

endmodule

// File: tb/tb_sid_audio_out.sv
// Self-checking bench for sid_audio_out: directed and random samples against an arithmetic model.
module tb_sid_audio_out;
  logic        clk;
  logic        rst_n;
  logic        dac_out;
  logic [14:0] level;
  int          checks;
  int          failures;

  sid_audio_out_if #(.SAMPLE_W(15)) bus ();

  sid_audio_out #(.SAMPLE_W(15), .MIDPOINT(16384)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .dac_out (dac_out),
    .level   (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_level(input int smp, input int vv);
    int s;
    int p;
    s = smp - 16384;
    p = s * vv;
    return (p >>> 4) + 16384;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe one sample at edge N and follow it to edge N+5
  task automatic run_sample(input int smp, input int vv, input string tag);
    int exp;
    exp = model_level(smp, vv);
    bus.sample_in    = 15'(smp);
    bus.vol          = 4'(vv);
    bus.sample_ready = 1'b1;
    tick();
    bus.sample_ready = 1'b0;
    check({tag, "_busy_n"}, 32'(bus.busy), 32'd1);
    check({tag, "_ovr_n"}, 32'(bus.overrun), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check({tag, "_busy_mid"}, 32'(bus.busy), 32'd1);
      check({tag, "_ovr_mid"}, 32'(bus.overrun), 32'd0);
    end
    tick();
    check({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
    check({tag, "_level"}, 32'(level), 32'(exp));
  endtask

  initial begin
    int cnt;
    int exp;
    int smp;
    int vv;
    checks           = 0;
    failures         = 0;
    rst_n            = 1'b0;
    bus.sample_in    = '0;
    bus.sample_ready = 1'b0;
    bus.vol          = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_level", 32'(level), 32'd16384);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    check("rst_dac", 32'(dac_out), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("idle_dac_alt", 32'(dac_out), 32'(i & 1));
    end

    run_sample(17984, 15, "full_vol");
    run_sample(15384, 8, "neg_swing");
    run_sample(12345, 0, "vol_zero");
    run_sample(0, 15, "min_full");
    run_sample(32767, 1, "max_v1");

    // Overrun: second strobe two cycles after the first is dropped
    exp = model_level(20000, 11);
    bus.sample_in    = 15'(20000);
    bus.vol          = 4'(11);
    bus.sample_ready = 1'b1;
    tick();
    bus.sample_ready = 1'b0;
    tick();
    bus.sample_in    = '0;
    bus.vol          = 4'(15);
    bus.sample_ready = 1'b1;
    tick();
    bus.sample_ready = 1'b0;
    check("ovr_pulse", 32'(bus.overrun), 32'd1);
    tick();
    check("ovr_clear", 32'(bus.overrun), 32'd0);
    tick();
    tick();
    check("ovr_busy_done", 32'(bus.busy), 32'd0);
    check("ovr_level", 32'(level), 32'(exp));
    tick();
    check("ovr_stays_idle", 32'(bus.busy), 32'd0);
    check("ovr_level_hold", 32'(level), 32'(exp));

    // Strobe during LOAD is also an overrun
    bus.sample_in    = 15'(30000);
    bus.vol          = 4'(3);
    bus.sample_ready = 1'b1;
    tick();
    bus.sample_ready = 1'b1;
    bus.sample_in    = '0;
    repeat (4) tick();
    bus.sample_ready = 1'b1;
    tick();
    bus.sample_ready = 1'b0;
    check("ovr_load_pulse", 32'(bus.overrun), 32'd1);
    check("ovr_load_level", 32'(level), 32'(model_level(30000, 3)));
    tick();

    // Reset mid-multiply
    bus.sample_in    = 15'(25000);
    bus.vol          = 4'(9);
    bus.sample_ready = 1'b1;
    tick();
    bus.sample_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_level", 32'(level), 32'd16384);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_sample(25000, 9, "after_rst");

    // Back-to-back random samples
    for (int i = 0; i < 24; i++) begin
      smp = int'($urandom_range(0, 32767));
      vv  = int'($urandom_range(0, 15));
      run_sample(smp, vv, "rand");
    end

    // Duty cycle at maximum level
    run_sample(32767, 15, "duty");
    exp = model_level(32767, 15);
    tick();
    cnt = 0;
    for (int i = 0; i < 32768; i++) begin
      tick();
      cnt += int'(dac_out);
    end
    checks++;
    assert (cnt >= exp - 1 && cnt <= exp + 1) else begin
      failures++;
      $error("FAIL duty_count observed=%0d expected=%0d+-1", cnt, exp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
